// File: rtl/stopwatch_core.sv
// BCD stopwatch core: counts mm:ss.t from an upstream tenth-second tick, driven by
// start/stop and clear buttons through an IDLE/RUN/PAUSE state machine.
// Optional lap-freeze display is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
  parameter logic [7:0] TICKS_PER_UNIT = 8'd1,
  parameter logic [6:0] MIN_MAX        = 7'd99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       btn_lap,
  output logic       running,
  output logic       ovf,
  output logic       lap_hold,
  output logic [3:0] d_tenths,
  output logic [3:0] d_sec_o,
  output logic [3:0] d_sec_t,
  output logic [3:0] d_min_o,
  output logic [3:0] d_min_t
);

  localparam logic [3:0] MinMaxT = 4'(MIN_MAX / 7'd10);
  localparam logic [3:0] MinMaxO = 4'(MIN_MAX % 7'd10);
  localparam logic [7:0] PreMax  = TICKS_PER_UNIT - 8'd1;

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e     state_q, state_d;
  logic [2:0] ss_q, clr_q;
  logic       ss_ev, clr_ev;
  logic       running_q, ovf_q, ovf_d;
  logic [7:0] presc_q, presc_d;
  logic [3:0] tenths_q, sec_o_q, sec_t_q, min_o_q, min_t_q;
  logic [3:0] tenths_d, sec_o_d, sec_t_d, min_o_d, min_t_d;

  // Button synchronizers: [0] and [1] synchronize, [2] delays for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_q  <= 3'b000;
      clr_q <= 3'b000;
    end else begin
      ss_q  <= {ss_q[1:0], btn_ss};
      clr_q <= {clr_q[1:0], btn_clr};
    end
  end

  assign ss_ev  = ss_q[1] & ~ss_q[2];
  assign clr_ev = clr_q[1] & ~clr_q[2];

  // Next state: in RUN start/stop dominates, elsewhere clear wins
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (clr_ev)     state_d = StIdle;
        else if (ss_ev) state_d = StRun;
      end
      StRun: begin
        if (ss_ev) state_d = StPause;
      end
      StPause: begin
        if (clr_ev)     state_d = StIdle;
        else if (ss_ev) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  // Time next-state: zero in IDLE, advance on prescaled ticks seen while RUN
  always_comb begin
    presc_d  = presc_q;
    ovf_d    = ovf_q;
    tenths_d = tenths_q;
    sec_o_d  = sec_o_q;
    sec_t_d  = sec_t_q;
    min_o_d  = min_o_q;
    min_t_d  = min_t_q;
    if (state_d == StIdle) begin
      presc_d  = 8'd0;
      ovf_d    = 1'b0;
      tenths_d = 4'd0;
      sec_o_d  = 4'd0;
      sec_t_d  = 4'd0;
      min_o_d  = 4'd0;
      min_t_d  = 4'd0;
    end else if (state_q == StRun && tick) begin
      if (presc_q >= PreMax) begin
        presc_d = 8'd0;
        if (tenths_q < 4'd9) begin
          tenths_d = tenths_q + 4'd1;
        end else begin
          tenths_d = 4'd0;
          if (sec_o_q < 4'd9) begin
            sec_o_d = sec_o_q + 4'd1;
          end else begin
            sec_o_d = 4'd0;
            if (sec_t_q < 4'd5) begin
              sec_t_d = sec_t_q + 4'd1;
            end else begin
              sec_t_d = 4'd0;
              if (min_t_q == MinMaxT && min_o_q == MinMaxO) begin
                min_t_d = 4'd0;
                min_o_d = 4'd0;
                ovf_d   = 1'b1;
              end else if (min_o_q < 4'd9) begin
                min_o_d = min_o_q + 4'd1;
              end else begin
                min_o_d = 4'd0;
                min_t_d = (min_t_q < 4'd9) ? min_t_q + 4'd1 : 4'd0;
              end
            end
          end
        end
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end
  end

  // State, time and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
      presc_q   <= 8'd0;
      tenths_q  <= 4'd0;
      sec_o_q   <= 4'd0;
      sec_t_q   <= 4'd0;
      min_o_q   <= 4'd0;
      min_t_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == StRun);
      ovf_q     <= ovf_d;
      presc_q   <= presc_d;
      tenths_q  <= tenths_d;
      sec_o_q   <= sec_o_d;
      sec_t_q   <= sec_t_d;
      min_o_q   <= min_o_d;
      min_t_q   <= min_t_d;
    end
  end

  assign running = running_q;
  assign ovf     = ovf_q;

`ifdef STOPWATCH_LAP_EN
  logic [2:0]  lap_q;
  logic        lap_ev, lap_hold_q, lap_hold_d;
  logic [19:0] cap_q;

  assign lap_ev = lap_q[1] & ~lap_q[2];

  // Lap toggles only in RUN; IDLE always releases the freeze
  always_comb begin
    lap_hold_d = lap_hold_q;
    if (state_d == StIdle)               lap_hold_d = 1'b0;
    else if (state_q == StRun && lap_ev) lap_hold_d = ~lap_hold_q;
  end

  // Lap synchronizer, hold flag and capture of the live time on rising hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_q      <= 3'b000;
      lap_hold_q <= 1'b0;
      cap_q      <= 20'd0;
    end else begin
      lap_q      <= {lap_q[1:0], btn_lap};
      lap_hold_q <= lap_hold_d;
      if (lap_hold_d && !lap_hold_q) begin
        cap_q <= {min_t_q, min_o_q, sec_t_q, sec_o_q, tenths_q};
      end
    end
  end

  assign lap_hold = lap_hold_q;
  assign {d_min_t, d_min_o, d_sec_t, d_sec_o, d_tenths} = lap_hold_q ? cap_q :
      {min_t_q, min_o_q, sec_t_q, sec_o_q, tenths_q};
`else
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;
  assign lap_hold = 1'b0;
  assign {d_min_t, d_min_o, d_sec_t, d_sec_o, d_tenths} =
      {min_t_q, min_o_q, sec_t_q, sec_o_q, tenths_q};
`endif

endmodule
